// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the datapath
// (core) and a debug/loader port. When both ports request in the same cycle,
// the one not granted last wins. The debug port can also take the memory
// for itself with dbg_lock, which locks the core out.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   core_req/we/addr/wdata       core access request (one cycle per access)
//   core_gnt                     combinational: core access performed this cycle
//   core_rvalid/rdata            registered read return, one cycle after grant
//   dbg_*                        same as core_* for the debug/loader port
//   dbg_lock                     debug asks for exclusive ownership of memory
//   mem_we/addr/wdata            combinational mux of the granted port's access
//   mem_rdata                    combinational memory read data for mem_addr
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_DBG  = 1'b1;

  state_t state, state_nxt;
  logic   last_gnt, last_gnt_nxt;

  // Grant decision, lock entry/exit and round-robin pointer update.
  always_comb begin
    core_gnt     = 1'b0;
    dbg_gnt      = 1'b0;
    state_nxt    = state;
    last_gnt_nxt = last_gnt;

    case (state)
      ST_ARB: begin
        if (core_req && dbg_req) begin
          core_gnt = (last_gnt == GNT_DBG);
          dbg_gnt  = (last_gnt == GNT_CORE);
        end else begin
          core_gnt = core_req;
          dbg_gnt  = dbg_req;
        end
      end
      ST_LOCKED: begin
        dbg_gnt = dbg_req;
      end
      default: ;
    endcase

    // No access may reach memory while reset is held.
    if (!reset_n) begin
      core_gnt = 1'b0;
      dbg_gnt  = 1'b0;
    end

    if (core_gnt) last_gnt_nxt = GNT_CORE;
    if (dbg_gnt)  last_gnt_nxt = GNT_DBG;

    case (state)
      ST_ARB: begin
        // Lock only takes effect on an actual debug grant.
        if (dbg_gnt && dbg_lock) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!dbg_lock) begin
          state_nxt    = ST_ARB;
          last_gnt_nxt = GNT_DBG;
        end
      end
      default: ;
    endcase
  end

  // Memory-side mux of the granted access; idle bus is all zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // State and round-robin pointer; core wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_ARB;
      last_gnt <= GNT_DBG;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Read return: capture memory data at the edge of a granted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      core_rvalid <= core_gnt && !core_we;
      dbg_rvalid  <= dbg_gnt && !dbg_we;
      if (core_gnt && !core_we) core_rdata <= mem_rdata;
      if (dbg_gnt && !dbg_we)   dbg_rdata  <= mem_rdata;
    end
  end

endmodule
